// File: rtl/occf_pl_arbiter.sv
// Packet-level round-robin arbiter sharing one OCC fabric plain-interface sink
// between g_NUM_PORTS requesters. A port keeps the grant from SOF to EOF. The
// granted port is muxed onto the shared sink, and dreq is routed back to it.
// Framing violations on the granted stream raise err_o.
// Optional feature: define OCCF_ARB_TIMEOUT_EN to force release of a grant
// after g_TIMEOUT consecutive cycles without a granted dvalid beat.
module occf_pl_arbiter #(
  parameter int g_NUM_PORTS  = 4,
  parameter int g_ADDR_WIDTH = 4,
  parameter int g_DATA_WIDTH = 128,
  parameter int g_TIMEOUT    = 4096
) (
  input  logic                                     clk_i,
  input  logic                                     rst_n_i,
  input  logic [g_NUM_PORTS-1:0]                   req_i,
  input  logic [g_NUM_PORTS*g_ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [g_NUM_PORTS*g_DATA_WIDTH-1:0]      req_data_i,
  input  logic [g_NUM_PORTS-1:0]                   req_dvalid_i,
  input  logic [g_NUM_PORTS-1:0]                   req_sof_i,
  input  logic [g_NUM_PORTS-1:0]                   req_eof_i,
  input  logic [g_NUM_PORTS*(g_DATA_WIDTH/8)-1:0]  req_bytesel_i,
  output logic [g_NUM_PORTS-1:0]                   req_dreq_o,
  output logic [g_ADDR_WIDTH-1:0]                  addr_o,
  output logic [g_DATA_WIDTH-1:0]                  data_o,
  output logic                                     dvalid_o,
  output logic                                     sof_o,
  output logic                                     eof_o,
  output logic [g_DATA_WIDTH/8-1:0]                bytesel_o,
  input  logic                                     dreq_i,
  output logic [g_NUM_PORTS-1:0]                   grant_o,
  output logic                                     busy_o,
  output logic                                     err_o,
  output logic                                     timeout_o
);

  localparam int N  = g_NUM_PORTS;
  localparam int AW = g_ADDR_WIDTH;
  localparam int DW = g_DATA_WIDTH;
  localparam int BW = g_DATA_WIDTH / 8;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] last_q, last_d;
  logic [PW-1:0] pick;
  logic          any_req;
  logic          first_q, first_d;
  logic          err_q, err_d;
  logic          active;

`ifdef OCCF_ARB_TIMEOUT_EN
  localparam int CW = $clog2(g_TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  assign active  = |grant_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == XFER);
  assign err_o   = err_q;

  // Round-robin search: first requesting port above the last grant, with wrap.
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = last_q;
    any_req = 1'b0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last_q) + i) % N;
      if (req_i[idx]) begin
        pick    = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Shared-port mux of the granted requester; everything reads 0 with no grant.
  always_comb begin
    addr_o     = '0;
    data_o     = '0;
    bytesel_o  = '0;
    dvalid_o   = 1'b0;
    sof_o      = 1'b0;
    eof_o      = 1'b0;
    req_dreq_o = grant_q & {N{dreq_i}};
    if (active) begin
      addr_o    = req_addr_i[int'(last_q)*AW +: AW];
      data_o    = req_data_i[int'(last_q)*DW +: DW];
      bytesel_o = req_bytesel_i[int'(last_q)*BW +: BW];
      dvalid_o  = req_dvalid_i[last_q];
      sof_o     = req_sof_i[last_q];
      eof_o     = req_eof_i[last_q];
    end
  end

  // Next-state logic: arbitration in IDLE, framing check and release in XFER.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    first_d = first_q;
    err_d   = 1'b0;
`ifdef OCCF_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
          last_d  = pick;
          first_d = 1'b1;
          state_d = XFER;
`ifdef OCCF_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      XFER: begin
        if (dvalid_o) begin
          // First beat must carry sof; any later beat must not.
          err_d   = first_q ? ~sof_o : sof_o;
          first_d = 1'b0;
          if (eof_o) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
`ifdef OCCF_ARB_TIMEOUT_EN
        if (dvalid_o) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(g_TIMEOUT - 1)) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Control registers; the data path is purely combinational.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PW'(N - 1);
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

`ifdef OCCF_ARB_TIMEOUT_EN
  // Idle-cycle counter and the registered forced-release pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_occf_pl_arbiter.sv
// Scoreboard bench for occf_pl_arbiter: the driver pushes every granted beat
// into a queue and a negedge monitor pops and compares whatever the shared
// port presents. Grant order comes from a pointer-based reference model.
// The forced-release test runs only when OCCF_ARB_TIMEOUT_EN is defined.
module tb_occf_pl_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int BW = DW / 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n_i;
  logic [N-1:0]      req_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_dvalid_i, req_sof_i, req_eof_i;
  logic [N*BW-1:0]   req_bytesel_i;
  logic [N-1:0]      req_dreq_o;
  logic [AW-1:0]     addr_o;
  logic [DW-1:0]     data_o;
  logic              dvalid_o, sof_o, eof_o;
  logic [BW-1:0]     bytesel_o;
  logic              dreq_i;
  logic [N-1:0]      grant_o;
  logic              busy_o, err_o, timeout_o;

  occf_pl_arbiter #(
    .g_NUM_PORTS(N), .g_ADDR_WIDTH(AW), .g_DATA_WIDTH(DW), .g_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_dvalid_i(req_dvalid_i), .req_sof_i(req_sof_i),
    .req_eof_i(req_eof_i), .req_bytesel_i(req_bytesel_i), .req_dreq_o(req_dreq_o),
    .addr_o(addr_o), .data_o(data_o), .dvalid_o(dvalid_o), .sof_o(sof_o),
    .eof_o(eof_o), .bytesel_o(bytesel_o), .dreq_i(dreq_i), .grant_o(grant_o),
    .busy_o(busy_o), .err_o(err_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] bs;
    logic          sof;
    logic          eof;
    logic          err;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           ptr = N - 1;     // reference round-robin pointer
  int           cur_port = -1;   // port the model believes is granted
  logic [N-1:0] pend = '0;
  int           plen[N];
  int           pmode[N];        // 0 clean, 1 random sof flips, 2 fixed bad, 3 stall
  logic         prev_err = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] m);
    for (int i = 1; i <= N; i++)
      if (m[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // Non-granted ports chatter, including dvalid and a tell-tale data word.
  task automatic set_noise(input int g);
    for (int k = 0; k < N; k++) begin
      if (k != g) begin
        req_dvalid_i[k]          = 1'($urandom % 2);
        req_sof_i[k]             = 1'($urandom % 2);
        req_eof_i[k]             = 1'($urandom % 2);
        req_data_i[k*DW +: DW]   = 128'hDEAD;
        req_addr_i[k*AW +: AW]   = AW'($urandom);
        req_bytesel_i[k*BW +: BW] = BW'($urandom);
      end
    end
    dreq_i = 1'($urandom % 2);
  endtask

  task automatic quiet();
    req_dvalid_i = '0;
    req_sof_i    = '0;
    req_eof_i    = '0;
    dreq_i       = 1'($urandom % 2);
  endtask

  task automatic get_grant(output int g);
    int exp_g;
    int n;
    quiet();
    req_i = pend;
    exp_g = model_pick(pend);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (grant_o == '0 && n < 8);
    chk("grant_latency", 128'(n), 128'(1));
    chk("grant_port", 128'(grant_o), 128'(1) << exp_g);
    chk("timeout_idle", 128'(timeout_o), 128'(0));
    req_i[exp_g] = 1'b0;
    pend[exp_g]  = 1'b0;
    if (grant_o == '0) begin
      g = -1;
    end else begin
      g = exp_g;
      ptr = exp_g;
      cur_port = exp_g;
    end
  endtask

  task automatic drive_beat(input int g, input logic sof, input logic eof, input logic err);
    beat_t b;
    set_noise(g);
    b.addr = AW'($urandom);
    b.data = {$urandom, $urandom, $urandom, $urandom};
    b.bs   = BW'($urandom);
    b.sof  = sof;
    b.eof  = eof;
    b.err  = err;
    req_dvalid_i[g]           = 1'b1;
    req_sof_i[g]              = sof;
    req_eof_i[g]              = eof;
    req_addr_i[g*AW +: AW]    = b.addr;
    req_data_i[g*DW +: DW]    = b.data;
    req_bytesel_i[g*BW +: BW] = b.bs;
    exp_q.push_back(b);
    @(posedge clk); #1;
  endtask

  task automatic drive_gap(input int g);
    set_noise(g);
    req_dvalid_i[g] = 1'b0;
    req_sof_i[g]    = 1'($urandom % 2);
    req_eof_i[g]    = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_packet(input int g, input int len, input int mode, input int stop_after);
    logic sof;
    for (int b = 0; b < len && b < stop_after; b++) begin
      if (mode == 1 && $urandom % 3 == 0) drive_gap(g);
      sof = (b == 0);
      if (mode == 1 && $urandom % 4 == 0) sof = ~sof;
      if (mode == 2) sof = (b == 2);
      drive_beat(g, sof, b == len - 1, (b == 0) ? ~sof : sof);
    end
  endtask

  task automatic serve();
    int g;
    while (pend != '0) begin
      get_grant(g);
      if (g >= 0) begin
        if (pmode[g] == 3) begin
          stall_packet(g);
        end else begin
          send_packet(g, plen[g], pmode[g], 1000);
          cur_port = -1;
          chk("grant_clear_after_eof", 128'(grant_o), 128'(0));
        end
      end
    end
    quiet();
  endtask

  task automatic stall_packet(input int g);
    int n;
    drive_beat(g, 1'b1, 1'b0, 1'b0);
    quiet();
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (grant_o != '0 && n < 4 * TO);
    cur_port = -1;
`ifdef OCCF_ARB_TIMEOUT_EN
    chk("timeout_cycles", 128'(n), 128'(TO));
    chk("timeout_pulse", 128'(timeout_o), 128'(1));
`else
    chk("stall_release", 128'(n), 128'(4 * TO));
`endif
  endtask

  // Scoreboard monitor and per-cycle output rules.
  always @(negedge clk) begin
    logic [N-1:0] ed;
    beat_t b;
    if (!rst_n_i) begin
      prev_err = 1'b0;
    end else begin
      chk("err_o", 128'(err_o), 128'(prev_err));
      prev_err = 1'b0;
      chk("busy_o", 128'(busy_o), 128'(cur_port >= 0));
      ed = '0;
      if (cur_port >= 0 && dreq_i) ed[cur_port] = 1'b1;
      chk("req_dreq_o", 128'(req_dreq_o), 128'(ed));
`ifndef OCCF_ARB_TIMEOUT_EN
      chk("timeout_tied", 128'(timeout_o), 128'(0));
`endif
      if (dvalid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(data_o), 128'(0));
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", data_o, b.data);
          chk("beat_ctl", 128'({addr_o, bytesel_o, sof_o, eof_o}), 128'({b.addr, b.bs, b.sof, b.eof}));
          prev_err = b.err;
        end
      end else if (cur_port < 0) begin
        chk("idle_outputs", 128'({addr_o, bytesel_o, sof_o, eof_o}) | 128'(data_o), 128'(0));
      end
    end
  end

  initial begin
    int g;
    rst_n_i = 1'b0;
    req_i = '1;
    req_addr_i = '0;
    req_data_i = '0;
    req_bytesel_i = '0;
    req_dvalid_i = '1;
    req_sof_i = '0;
    req_eof_i = '0;
    dreq_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 128'(grant_o), 128'(0));
    chk("rst_dreq", 128'(req_dreq_o), 128'(0));
    chk("rst_flags", 128'({busy_o, err_o, timeout_o, dvalid_o}), 128'(0));
    req_i = '0;
    quiet();
    rst_n_i = 1'b1;
    @(posedge clk); #1;

    // Single requester, 3-beat clean packet.
    pend = 4'b0001; plen[0] = 3; pmode[0] = 0;
    serve();

    // All four request together: round-robin order.
    pend = 4'b1111;
    for (int k = 0; k < N; k++) begin plen[k] = 2; pmode[k] = 0; end
    serve();
    pend = 4'b0001; serve();

    // Framing errors on port 2 while port 1 chatters.
    pend = 4'b0100; plen[2] = 5; pmode[2] = 2;
    serve();

    // Random traffic.
    for (int r = 0; r < 25; r++) begin
      pend = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        plen[k]  = $urandom_range(1, 6);
        pmode[k] = $urandom % 2;
      end
      serve();
      repeat ($urandom % 3) begin quiet(); @(posedge clk); #1; end
    end

    // Single-beat packet on port 3.
    pend = 4'b1000; plen[3] = 1; pmode[3] = 0;
    serve();

    // Reset in the middle of an 8-beat packet.
    pend = 4'b0010;
    get_grant(g);
    if (g >= 0) send_packet(g, 8, 0, 3);
    quiet();
    rst_n_i = 1'b0;
    #1;
    chk("midrst_grant", 128'(grant_o), 128'(0));
    chk("midrst_outputs", 128'({dvalid_o, sof_o, eof_o, busy_o}) | 128'(data_o), 128'(0));
    ptr = N - 1;
    cur_port = -1;
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    pend = 4'b1111;
    for (int k = 0; k < N; k++) begin plen[k] = 2; pmode[k] = 0; end
    serve();

`ifdef OCCF_ARB_TIMEOUT_EN
    // Stalled packet released by the timeout; the other requester follows.
    pend = 4'b0101;
    plen[0] = 2; plen[2] = 2;
    pmode[0] = 3; pmode[2] = 3;
    pmode[model_pick(pend) == 0 ? 2 : 0] = 0;
    serve();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/occf_pl_arbiter.md
Name: occf_pl_arbiter

Overview:
- Packet-level round-robin arbiter that shares one OCC fabric plain-interface sink (the wb_occf_source plain input) between g_NUM_PORTS plain-interface requesters.
- Grants one requester for a whole packet, from SOF to EOF.
- Muxes the granted requester's addr/data/dvalid/sof/eof/bytesel onto the shared port and routes dreq back to the granted requester only.
- Flags framing violations on the granted stream.

Parameters:
g_NUM_PORTS, 4, number of requesters (2..16)
g_ADDR_WIDTH, 4, plain-interface address width
g_DATA_WIDTH, 128, plain-interface data width; multiple of 8
g_TIMEOUT, 4096, idle cycles inside a granted packet before forced release (used only with OCCF_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
req_i  in  N  per-port request, held high until grant_o bit seen
req_addr_i  in  N*g_ADDR_WIDTH  per-port address, port k at bits [k*AW +: AW]
req_data_i  in  N*g_DATA_WIDTH  per-port data
req_dvalid_i  in  N  per-port data valid
req_sof_i  in  N  per-port start of frame
req_eof_i  in  N  per-port end of frame
req_bytesel_i  in  N*(g_DATA_WIDTH/8)  per-port byte select
req_dreq_o  out  N  per-port data request
addr_o  out  g_ADDR_WIDTH  shared sink address
data_o  out  g_DATA_WIDTH  shared sink data
dvalid_o  out  1  shared sink data valid
sof_o  out  1  shared sink SOF
eof_o  out  1  shared sink EOF
bytesel_o  out  g_DATA_WIDTH/8  shared sink byte select
dreq_i  in  1  shared sink data request
grant_o  out  N  one-hot registered grant
busy_o  out  1  high while in XFER
err_o  out  1  one-cycle pulse on framing error
timeout_o  out  1  one-cycle pulse on forced release (0 without macro)

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE, grant_o=0, last-grant pointer=N-1, busy_o=0, err_o=0, timeout_o=0. All shared outputs and req_dreq_o read 0 while grant_o=0.
- FSM states: IDLE, XFER.
- IDLE:
  - If any req_i bit is set, pick the first set bit searching upward from last+1 with wrap (N-1 -> 0).
  - Register it into grant_o and last. Go to XFER next edge.
  - Latency from req_i rise to grant_o: 1 cycle.
- XFER:
  - Shared outputs are a combinational mux of the granted port.
  - dvalid_o/sof_o/eof_o are forced 0 if grant_o=0.
  - req_dreq_o[g]=dreq_i; all other req_dreq_o bits are 0.
  - Non-granted dvalid is ignored (dropped, not buffered).
  - First-word flag is set on entry to XFER.
  - A dvalid & eof beat on the granted port returns the FSM to IDLE next edge; grant_o clears the same edge.
  - A single-beat packet (sof & eof & dvalid in one cycle) is legal.
- Back-to-back: at least one IDLE cycle between packets. A req_i already high when EOF is accepted is arbitrated in that IDLE cycle, with pointer-based fairness.
- req_i deassertion during XFER has no effect; only EOF ends the grant.
- err_o pulses (registered, 1 cycle after the offending beat) on either:
  - the first dvalid beat without sof;
  - a non-first dvalid beat with sof.
- Beats that raise err_o are still forwarded unchanged.
- dvalid while dreq_i=0 is forwarded as-is; the arbiter does not police dreq compliance.
- Reset asserted mid-packet: immediate return to IDLE, grant cleared, pointer reset. The truncated packet is the sink's concern.

Optional Feature:
- Macro: OCCF_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on XFER entry and on every granted dvalid beat, and increments otherwise.
  - At g_TIMEOUT-1, the FSM goes to IDLE, grant_o clears, and timeout_o pulses 1 cycle.
  - No EOF is synthesised.
  - The pointer still advances past the timed-out port.
- When undefined: no counter; timeout_o tied 0; a stalled requester holds the grant indefinitely.

Test Plan:
- Reset, then req_i=4'b0001, port0 sends 3 beats (sof on beat 0, eof on beat 2) -> grant_o=0001 one cycle after req_i; 3 beats appear on the shared port with identical data; grant_o=0 after EOF; err_o never set.
- req_i=4'b1111 held, each port sends 2-beat packets -> grant order 0,1,2,3,0; exactly one IDLE cycle between grants; req_dreq_o only on the granted bit.
- Port2 granted, port1 drives dvalid=1 with data 0xDEAD -> data_o never shows 0xDEAD; req_dreq_o[1]=0 throughout.
- Granted port sends first beat without sof, then a mid-packet beat with sof -> err_o pulses twice, each 1 cycle after the bad beat; all beats are forwarded.
- Single-beat packet (sof=eof=dvalid=1) on port3 -> one beat out, grant held exactly 1 cycle; rst_n_i pulsed mid 8-beat packet -> grant_o=0 and outputs 0 immediately, next grant starts at port0.
- With OCCF_ARB_TIMEOUT_EN and g_TIMEOUT=16, granted port sends sof then stalls -> timeout_o pulses at the 16th idle cycle; the pending port is granted next.
